// File: rtl/ifetch.sv
// ifetch: instruction fetch front end.
// Holds the fetch PC and a two-entry in-order output buffer toward decode.
// A small IDLE/WAIT/DROP sequencer drives a single-outstanding request
// memory port. On a branch or jump redirect the buffer is flushed and
// fetching restarts from the new address. If a request is still open when
// the redirect arrives, its response is discarded when it returns.
// Optional build macro: IFETCH_ALIGN_CHECK_EN. When it is defined, a
// misaligned redirect target is rejected and raises the sticky addr_err.
// When it is undefined, the low two target bits are cleared and addr_err
// is tied low.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  opcode,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Buffer occupancy that still leaves room for one more fetch.
  function automatic logic room_for_fetch(input logic [1:0] cnt);
    return (cnt < 2'd2);
  endfunction

  // Registered state
  state_t      state_r;
  logic [31:0] pc_r;          // next address to fetch (or redirect target while dropping)
  logic [31:0] addr_r;        // address currently presented to memory
  logic [1:0]  count_r;       // buffer occupancy, 0..2
  logic [31:0] ent0_inst_r;   // buffer head
  logic [31:0] ent0_pc_r;
  logic [31:0] ent1_inst_r;   // buffer second entry
  logic [31:0] ent1_pc_r;

  // Combinational helpers
  logic        redir_s;       // redirect that actually takes effect
  logic [31:0] redir_pc_s;    // target address used on an effective redirect
  logic        issue_ok_s;
  logic        fetch_done_s;  // request completes this cycle
  logic        push_s;
  logic        pop_s;
  state_t      state_nxt_s;
  logic [31:0] pc_nxt_s;
  logic [31:0] addr_nxt_s;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_s;
  logic addr_err_r;

  // Reject misaligned targets; an accepted target is used as-is.
  always_comb begin
    misalign_s = redirect && (redirect_pc[1:0] != 2'b00);
    redir_s    = redirect && !misalign_s;
    redir_pc_s = redirect_pc;
  end

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_r <= 1'b0;
    end else if (misalign_s) begin
      addr_err_r <= 1'b1;
    end
  end

  assign addr_err = addr_err_r;
`else
  // Every redirect is taken; its target is forced to a word boundary.
  always_comb begin
    redir_s    = redirect;
    redir_pc_s = redirect_pc & 32'hFFFF_FFFC;
  end

  assign addr_err = 1'b0;
`endif

  assign issue_ok_s = room_for_fetch(count_r);

  // Memory request. In IDLE a fetch starts only when the buffer has room
  // and no redirect is arriving. In WAIT/DROP the open request stays
  // asserted until its ack. Reset kills the request immediately.
  always_comb begin
    imem_req = 1'b0;
    if (rst) begin
      imem_req = 1'b0;
    end else if (state_r == S_IDLE) begin
      imem_req = issue_ok_s && !redir_s;
    end else begin
      imem_req = 1'b1;
    end
  end

  assign imem_addr = addr_r;

  // Transfer qualifiers. A redirect discards incoming data and overrides any pop.
  always_comb begin
    fetch_done_s = imem_req && imem_ack;
    push_s       = fetch_done_s && (state_r != S_DROP) && !redir_s;
    pop_s        = inst_valid && inst_ready && !redir_s;
  end

  // Sequencer next state and fetch PC.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      S_IDLE: begin
        if (redir_s) begin
          pc_nxt_s = redir_pc_s;
        end else if (imem_req) begin
          if (imem_ack) begin
            pc_nxt_s = pc_inc(pc_r);
          end else begin
            state_nxt_s = S_WAIT;
          end
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_nxt_s = S_IDLE;
          if (redir_s) begin
            pc_nxt_s = redir_pc_s;
          end else begin
            pc_nxt_s = pc_inc(pc_r);
          end
        end else if (redir_s) begin
          // Response still pending: keep the port stable and drop its data later.
          pc_nxt_s    = redir_pc_s;
          state_nxt_s = S_DROP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_DROP: begin
        if (redir_s) begin
          pc_nxt_s = redir_pc_s;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (imem_ack) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DROP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        pc_nxt_s    = pc_r;
      end
    endcase
  end

  // Memory address tracks the PC whenever the port is free. It is frozen
  // while a request is open.
  always_comb begin
    if (state_nxt_s == S_IDLE) begin
      addr_nxt_s = pc_nxt_s;
    end else begin
      addr_nxt_s = addr_r;
    end
  end

  // Sequencer, PC and presented-address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

  // Two-entry output buffer. Entry 0 is always the head, so the decode
  // outputs come straight from registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r     <= 2'd0;
      ent0_inst_r <= 32'd0;
      ent0_pc_r   <= 32'd0;
      ent1_inst_r <= 32'd0;
      ent1_pc_r   <= 32'd0;
    end else if (redir_s) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            ent0_inst_r <= imem_rdata;
            ent0_pc_r   <= addr_r;
          end else begin
            ent1_inst_r <= imem_rdata;
            ent1_pc_r   <= addr_r;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          ent0_inst_r <= ent1_inst_r;
          ent0_pc_r   <= ent1_pc_r;
          count_r     <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            ent0_inst_r <= imem_rdata;
            ent0_pc_r   <= addr_r;
          end else begin
            ent0_inst_r <= ent1_inst_r;
            ent0_pc_r   <= ent1_pc_r;
            ent1_inst_r <= imem_rdata;
            ent1_pc_r   <= addr_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign inst_valid = (count_r != 2'd0);
  assign inst       = ent0_inst_r;
  assign inst_pc    = ent0_pc_r;
  assign opcode     = ent0_inst_r[31:26];

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch (table-driven plus scoreboard).
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ack_mode;    // 1: zero-wait memory (ack = req); 0: ack_force
  logic        ack_force;
  logic        mon_en;
  logic        no_redirect;

  logic        imem_req, imem_ack, inst_valid, addr_err;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
  logic [5:0]  opcode;

  logic        imem_req2, imem_ack2, inst_valid2, addr_err2;
  logic [31:0] imem_addr2, imem_rdata2, inst2, inst_pc2;
  logic [5:0]  opcode2;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  // Memory contents as a function of address
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[5:0], a[31:6]} ^ 32'h1234_5678;
  endfunction

  assign imem_ack    = ack_mode ? imem_req : ack_force;
  assign imem_rdata  = mem_data(imem_addr);
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = mem_data(imem_addr2);

  ifetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
    .redirect(redirect), .redirect_pc(redirect_pc), .addr_err(addr_err)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .inst_valid(inst_valid2),
    .inst_ready(inst_ready), .inst(inst2), .inst_pc(inst_pc2), .opcode(opcode2),
    .redirect(no_redirect), .redirect_pc(32'h0000_0000), .addr_err(addr_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
    next_cyc();
    rst = 1'b0;
  endtask

  // Scoreboard: every accepted transfer pops the oldest expected address
  always @(negedge clk) begin
    if (mon_en && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got pc %h expected none", inst_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst, mem_data(e));
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] d;
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    no_redirect = 1'b0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    ack_mode = 1'b1;
    ack_force = 1'b0;
    rst = 1'b1;

    // Stall for five cycles after reset, then stream with zero-wait memory
    tbl[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1] = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    tbl[2] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h00};
    tbl[3] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h00};
    tbl[4] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h00};
    tbl[5] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
    tbl[6] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    tbl[7] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    tbl[8] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    tbl[9] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10};

    // Table scenario: stall buffering then one-per-cycle streaming
    do_reset();
    exp_q = {32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      inst_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("t%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
      chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("t%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        d = mem_data(tbl[i].exp_pc);
        chk($sformatf("t%0d_pc", i), inst_pc, tbl[i].exp_pc);
        chk($sformatf("t%0d_opcode", i), {26'd0, opcode}, {26'd0, d[31:26]});
      end
      next_cyc();
    end
    mon_en = 1'b0;
    chk("t_drain", exp_q.size(), 32'd0);

    // Slow ack with redirect in the first wait cycle
    ack_mode = 1'b0;
    ack_force = 1'b0;
    inst_ready = 1'b1;
    do_reset();
    exp_q = {32'h100, 32'h104};
    mon_en = 1'b1;
    @(negedge clk);
    chk("b_c0_req", {31'd0, imem_req}, 32'd1);
    chk("b_c0_addr", imem_addr, 32'h0);
    next_cyc();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    chk("b_c1_addr", imem_addr, 32'h0);
    next_cyc();
    redirect = 1'b0;
    @(negedge clk);
    chk("b_c2_req", {31'd0, imem_req}, 32'd1);
    chk("b_c2_addr", imem_addr, 32'h0);
    next_cyc();
    ack_force = 1'b1;
    @(negedge clk);
    chk("b_c3_addr", imem_addr, 32'h0);
    next_cyc();
    ack_force = 1'b0;
    ack_mode = 1'b1;
    @(negedge clk);
    chk("b_c4_addr", imem_addr, 32'h100);
    chk("b_c4_valid", {31'd0, inst_valid}, 32'd0);
    next_cyc();
    @(negedge clk);
    chk("b_c5_valid", {31'd0, inst_valid}, 32'd1);
    next_cyc();
    @(negedge clk);
    next_cyc();
    mon_en = 1'b0;
    chk("b_drain", exp_q.size(), 32'd0);

    // Redirect with a full buffer and decode ready: no pop, flush
    ack_mode = 1'b1;
    inst_ready = 1'b0;
    do_reset();
    exp_q = {32'h40};
    mon_en = 1'b1;
    next_cyc();
    next_cyc();
    inst_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    chk("c_req_redir", {31'd0, imem_req}, 32'd0);
    chk("c_full_pc", inst_pc, 32'h0);
    next_cyc();
    redirect = 1'b0;
    @(negedge clk);
    chk("c_valid_flush", {31'd0, inst_valid}, 32'd0);
    chk("c_addr", imem_addr, 32'h40);
    next_cyc();
    @(negedge clk);
    chk("c_pc", inst_pc, 32'h40);
    next_cyc();
    mon_en = 1'b0;
    chk("c_drain", exp_q.size(), 32'd0);

    // PC wrap from a high reset address
    inst_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("d_addr0", imem_addr2, 32'hFFFF_FFF8);
    next_cyc();
    @(negedge clk);
    chk("d_addr1", imem_addr2, 32'hFFFF_FFFC);
    chk("d_pc1", inst_pc2, 32'hFFFF_FFF8);
    next_cyc();
    @(negedge clk);
    chk("d_addr2", imem_addr2, 32'h0000_0000);
    chk("d_pc2", inst_pc2, 32'hFFFF_FFFC);
    next_cyc();
    @(negedge clk);
    chk("d_pc3", inst_pc2, 32'h0000_0000);
    next_cyc();

    // Misaligned redirect target
    inst_ready = 1'b1;
    do_reset();
    next_cyc();
    redirect = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("e_req", {31'd0, imem_req}, 32'd1);
`else
    chk("e_req", {31'd0, imem_req}, 32'd0);
`endif
    next_cyc();
    redirect = 1'b0;
    @(negedge clk);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("e_addr", imem_addr, 32'h8);
    chk("e_addr_err", {31'd0, addr_err}, 32'd1);
`else
    chk("e_addr", imem_addr, 32'h100);
    chk("e_addr_err", {31'd0, addr_err}, 32'd0);
`endif
    next_cyc();
    @(negedge clk);
    chk("e_valid", {31'd0, inst_valid}, 32'd1);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("e_pc", inst_pc, 32'h8);
`else
    chk("e_pc", inst_pc, 32'h100);
`endif
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 imem_req  out  1  instruction-memory request; imem_addr held stable while high until imem_ack.
REQ-005 imem_addr  out  32  word-aligned fetch address.
REQ-006 imem_ack  in  1  request completion; may assert in the same cycle as imem_req or any later cycle.
REQ-007 imem_rdata  in  32  instruction word, valid only when imem_ack=1.
REQ-008 inst_valid  out  1  head of output buffer valid toward decode/control.
REQ-009 inst_ready  in  1  decode accepts; transfer when inst_valid & inst_ready.
REQ-010 inst  out  32  head instruction word.
REQ-011 inst_pc  out  32  address of head instruction.
REQ-012 opcode  out  6  inst[31:26], driven to the control decoder.
REQ-013 redirect  in  1  one-cycle branch/jump taken pulse.
REQ-014 redirect_pc  in  32  new fetch address, sampled when redirect=1.
REQ-015 addr_err  out  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 The block SHALL hold a fetch PC, a 2-entry in-order output FIFO, and an FSM {IDLE, WAIT, DROP}.
REQ-017 A request SHALL issue only when (FIFO count + requests in flight) < 2; at most one request outstanding.
REQ-018 IDLE: if issue allowed, imem_req=1 with imem_addr=PC; ack in the same cycle pushes {rdata, PC}, PC+=4, stay IDLE; otherwise go WAIT.
REQ-019 WAIT: imem_req=1, imem_addr unchanged; on imem_ack push {rdata, addr}, PC+=4, go IDLE.
REQ-020 With zero-wait memory and inst_ready held high, throughput SHALL be one instruction per cycle; push-to-inst_valid latency is one cycle.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-022 redirect=1 SHALL flush the FIFO (inst_valid=0 next cycle), load PC=redirect_pc, and ignore any simultaneous pop.
REQ-023 redirect in IDLE or with an ack this cycle: ack data discarded, no PC increment, next request from redirect_pc the following cycle.
REQ-024 redirect in WAIT without ack: imem_req/imem_addr stay held, go DROP; in DROP the ack data SHALL be discarded, then go IDLE.
REQ-025 redirect while in DROP SHALL update PC only; state stays DROP.
REQ-026 imem_req SHALL never be asserted in the same cycle as redirect from IDLE.

Reset
REQ-027 rst SHALL asynchronously force: PC=RESET_PC, FSM=IDLE, FIFO empty, inst_valid=0, imem_req=0, addr_err=0; inst/inst_pc/opcode=0.
REQ-028 First imem_req SHALL assert in the first cycle after rst deasserts, with imem_addr=RESET_PC.
REQ-029 rst mid-request SHALL abandon the outstanding request; a late imem_ack after reset is not received (memory also reset).

Configuration
REQ-030 Macro IFETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 SHALL set addr_err (sticky until rst) and SHALL be ignored entirely (no flush, no PC change).
REQ-031 Macro IFETCH_ALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be forced to 0 and addr_err tied 0.

Verification
REQ-032 Reset release, imem_ack=imem_req, inst_ready=1, rdata=addr -> imem_addr 0,4,8,... each cycle; inst_pc 0,4,8 one cycle behind.
REQ-033 inst_ready=0 for 5 cycles -> exactly 2 entries buffered (pc 0,4), imem_req=0 after; release -> pc 0,4,8 delivered in order, none lost.
REQ-034 Ack delayed 3 cycles with redirect to 32'h100 in first wait cycle -> addr held 0 until ack, that data dropped, next imem_addr=32'h100, first inst_pc=32'h100.
REQ-035 Redirect to 32'h40 with 2 entries buffered and inst_ready=1 -> no pop occurs, inst_valid=0 next cycle, next delivered inst_pc=32'h40.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 With IFETCH_ALIGN_CHECK_EN, redirect to 32'h102 -> addr_err=1, sequential fetch continues; without it -> next imem_addr=32'h100, addr_err=0.
